grid_vga_renderer: RTL and testbench



---
 rtl/grid_vga_renderer.sv | 143 ++++++++++++++
 tb/tb_grid_vga_renderer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/grid_vga_renderer.sv
// 16x16 occupancy grid to 640x480 VGA scan-out, 25 MHz tick from 100 MHz clk.
// Optional GRID_LINES_EN draws cell outlines in LINE_COLOR.
module grid_vga_renderer #(
  parameter int          X0           = 128,
  parameter int          Y0           = 48,
  parameter int          CELL_PX      = 24,
  parameter logic [11:0] FG_COLOR     = 12'hF80,
  parameter logic [11:0] BG_COLOR     = 12'h000,
  parameter logic [11:0] BORDER_COLOR = 12'h444,
  parameter logic [11:0] LINE_COLOR   = 12'h222
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic [255:0] grid_in,
  output logic [11:0]  rgb,
  output logic         hsync,
  output logic         vsync,
  output logic         active,
  output logic         frame_start,
  output logic         snapshot
);

  localparam int GW = 16 * CELL_PX;
  localparam int OW = (CELL_PX > 1) ? $clog2(CELL_PX) : 1;
  localparam logic [9:0] XL = 10'(X0);
  localparam logic [9:0] XH = 10'(X0 + GW);
  localparam logic [9:0] YL = 10'(Y0);
  localparam logic [9:0] YH = 10'(Y0 + GW);
  localparam logic [OW-1:0] OM = OW'(CELL_PX - 1);

  logic [1:0]    div;
  logic          tick;
  logic [9:0]    hc, vc, hc_nxt, vc_nxt;
  logic          hwrap, vis, in_x, in_y, in_grid;
  logic          snap_now, fs_now, line_px;
  logic [OW-1:0] xo, yo;
  logic [3:0]    col, row;
  logic [255:0]  shadow;
  logic [11:0]   pix;

  assign tick     = (div == 2'd3) && enable;
  assign hwrap    = (hc == 10'd799);
  assign hc_nxt   = hwrap ? 10'd0 : hc + 10'd1;
  assign vc_nxt   = !hwrap ? vc :
                    (vc == 10'd524) ? 10'd0 : vc + 10'd1;
  assign vis      = (hc < 10'd640) && (vc < 10'd480);
  assign in_x     = (hc >= XL) && (hc < XH);
  assign in_y     = (vc >= YL) && (vc < YH);
  assign in_grid  = in_x && in_y;
  assign fs_now   = (hc == 10'd0) && (vc == 10'd0);
  assign snap_now = (hc == 10'd0) && (vc == 10'd480);

`ifdef GRID_LINES_EN
  assign line_px = (xo == '0) || (yo == '0);
`else
  assign line_px = 1'b0;
`endif

  always_comb begin
    pix = BORDER_COLOR;
    if (!vis)
      pix = 12'h000;
    else if (in_grid) begin
      if (line_px)
        pix = LINE_COLOR;
      else if (shadow[{col, row}])
        pix = FG_COLOR;
      else
        pix = BG_COLOR;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div <= 2'd0;
      hc  <= 10'd0;
      vc  <= 10'd0;
    end else begin
      if (enable) div <= div + 2'd1;
      if (tick) begin
        hc <= hc_nxt;
        vc <= vc_nxt;
      end
    end
  end

  // Cell/offset counters track the pixel that hc/vc will hold next
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      xo  <= '0;
      col <= 4'd0;
      yo  <= '0;
      row <= 4'd0;
    end else if (tick) begin
      if (hc_nxt == XL) begin
        xo  <= '0;
        col <= 4'd0;
      end else if (in_x) begin
        if (xo == OM) begin
          xo  <= '0;
          col <= col + 4'd1;
        end else
          xo <= xo + 1'b1;
      end
      if (hwrap) begin
        if (vc_nxt == YL) begin
          yo  <= '0;
          row <= 4'd0;
        end else if (in_y) begin
          if (yo == OM) begin
            yo  <= '0;
            row <= row + 4'd1;
          end else
            yo <= yo + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow      <= '0;
      rgb         <= 12'h000;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      active      <= 1'b0;
      frame_start <= 1'b0;
      snapshot    <= 1'b0;
    end else begin
      frame_start <= tick && fs_now;
      snapshot    <= tick && snap_now;
      if (tick) begin
        rgb    <= pix;
        hsync  <= !((hc >= 10'd656) && (hc <= 10'd751));
        vsync  <= !((vc == 10'd490) || (vc == 10'd491));
        active <= vis;
        if (snap_now) shadow <= grid_in;
      end
    end
  end

endmodule

// File: tb/tb_grid_vga_renderer.sv
// Bench for grid_vga_renderer: per-line pixel-index model plus directed probes.
// Build with +define+GRID_LINES_EN to exercise the grid-line variant.
module tb_grid_vga_renderer;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic [255:0] grid_in;
  logic [11:0]  rgb;
  logic         hsync, vsync, active, frame_start, snapshot;

  grid_vga_renderer dut (
    .clk(clk), .reset(reset), .enable(enable), .grid_in(grid_in),
    .rgb(rgb), .hsync(hsync), .vsync(vsync), .active(active),
    .frame_start(frame_start), .snapshot(snapshot)
  );

  always #5 clk = ~clk;

`ifdef GRID_LINES_EN
  localparam logic [11:0] EDGE_BG = 12'h222;
`else
  localparam logic [11:0] EDGE_BG = 12'h000;
`endif
  localparam logic [16:0] RST_O = {12'h000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  int vectors = 0;
  int miscompares = 0;
  int ecnt, mpix, lpix, cyc, line_err, bad_pix, h, v;
  bit last_tk;
  logic [16:0]  exp_o, obs_o, bad_o, bad_e;
  logic [255:0] msh;

  function automatic logic [11:0] ref_rgb(int x, int y, logic [255:0] sh);
    int cx, cy;
    if (x >= 640 || y >= 480) return 12'h000;
    if (x < 128 || x >= 128 + 16 * 24 || y < 48 || y >= 48 + 16 * 24)
      return 12'h444;
    cx = (x - 128) / 24;
    cy = (y - 48) / 24;
`ifdef GRID_LINES_EN
    if ((x - 128) % 24 == 0 || (y - 48) % 24 == 0) return 12'h222;
`endif
    return sh[cy + 16 * cx] ? 12'hF80 : 12'h000;
  endfunction

  task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic model_reset();
    ecnt = 0; mpix = 0; lpix = -1; msh = '0;
    exp_o = RST_O; line_err = 0; last_tk = 0;
  endtask

  // One clk: advance the model by pixel index, compare every output.
  task automatic step();
    bit tk;
    @(posedge clk);
    cyc++;
    tk = 0;
    if (enable) begin
      ecnt++;
      tk = (ecnt % 4 == 0);
    end
    exp_o[1:0] = 2'b00;
    if (tk) begin
      h = mpix % 800;
      v = mpix / 800;
      exp_o = {ref_rgb(h, v, msh), !(h >= 656 && h <= 751),
               !(v == 490 || v == 491), (h < 640 && v < 480),
               mpix == 0, mpix == 480 * 800};
      if (mpix == 480 * 800) msh = grid_in;
      lpix = mpix;
      mpix = (mpix + 1) % 420000;
    end
    last_tk = tk;
    #1;
    obs_o = {rgb, hsync, vsync, active, frame_start, snapshot};
    if (obs_o !== exp_o) begin
      if (line_err == 0) begin
        bad_pix = lpix; bad_o = obs_o; bad_e = exp_o;
      end
      line_err++;
    end
    if (tk && h == 799) begin
      vectors++;
      assert (line_err == 0) else begin
        miscompares++;
        $error("FAIL line_%0d: %0d bad clk, first at pix %0d observed %h expected %h",
               v, line_err, bad_pix, bad_o, bad_e);
      end
      line_err = 0;
    end
  endtask

  task automatic run_to(int x, int y);
    int t, n;
    t = y * 800 + x;
    n = 0;
    while (n < 1_800_000) begin
      step();
      n++;
      if (last_tk && lpix == t) break;
    end
    vectors++;
    assert (n < 1_800_000) else begin
      miscompares++;
      $error("FAIL run_to_%0d_%0d: observed timeout expected tick", x, y);
    end
  endtask

  int lo, f0, c0;
  logic [16:0] held;

  initial begin
    cyc = 0;
    model_reset();
    reset = 1'b0;
    enable = 1'b1;
    grid_in = '0;
    grid_in[0] = 1'b1;
    grid_in[255] = 1'b1;
    #20;
    chk("rst_rgb", 32'(rgb), 32'h000);
    chk("rst_hsync", 32'(hsync), 32'd1);
    chk("rst_vsync", 32'(vsync), 32'd1);
    chk("rst_active", 32'(active), 32'd0);
    chk("rst_fs", 32'(frame_start), 32'd0);
    chk("rst_snap", 32'(snapshot), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    model_reset();

    repeat (3) step();
    chk("pre_tick_fs", 32'(frame_start), 32'd0);
    step();
    chk("first_tick_fs", 32'(frame_start), 32'd1);
    f0 = cyc;

    run_to(0, 1);
    lo = 0;
    repeat (3200) begin
      step();
      if (!hsync) lo++;
    end
    chk("hsync_low_clk", lo, 384);

    run_to(0, 10);
    c0 = cyc;
    run_to(300, 10);
    held = {rgb, hsync, vsync, active, frame_start, snapshot};
    enable = 1'b0;
    repeat (100) step();
    chk("hold_outputs", 32'({rgb, hsync, vsync, active, frame_start, snapshot}),
        32'(held));
    enable = 1'b1;
    run_to(0, 11);
    chk("line_clk_with_hold", cyc - c0, 3300);

    run_to(127, 48);
    chk("f0_border", 32'(rgb), 32'h444);
    run_to(129, 49);
    chk("f0_blank_cell", 32'(rgb), 32'h000);

    run_to(0, 480);
    chk("snapshot_pulse", 32'(snapshot), 32'd1);
    step();
    chk("snapshot_clear", 32'(snapshot), 32'd0);

    run_to(0, 489);
    lo = 0;
    repeat (9600) begin
      step();
      if (!vsync) lo++;
    end
    chk("vsync_low_clk", lo, 6400);

    run_to(0, 0);
    chk("f1_frame_start", 32'(frame_start), 32'd1);
    chk("frame_period", cyc - f0, 1_680_100);
    run_to(127, 48);
    chk("f1_127_48", 32'(rgb), 32'h444);
    run_to(129, 49);
    chk("f1_129_49", 32'(rgb), 32'hF80);
    run_to(151, 71);
    chk("f1_151_71", 32'(rgb), 32'hF80);
    run_to(152, 72);
    chk("f1_152_72", 32'(rgb), 32'(EDGE_BG));

    run_to(0, 200);
    for (int i = 0; i < 8; i++) grid_in[32*i +: 32] = $urandom;
    grid_in[0] = 1'b0;
    grid_in[255] = 1'b0;
    run_to(489, 409);
    chk("tear_489_409", 32'(rgb), 32'hF80);
    run_to(511, 431);
    chk("tear_511_431", 32'(rgb), 32'hF80);
    run_to(512, 431);
    chk("f1_512_431", 32'(rgb), 32'h444);

    run_to(129, 49);
    chk("f2_new_129_49", 32'(rgb), 32'h000);
    run_to(0, 300);
    grid_in = '1;
    #2;
    reset = 1'b0;
    #1;
    chk("async_reset", 32'({rgb, hsync, vsync, active, frame_start, snapshot}),
        32'(RST_O));
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    run_to(129, 49);
    chk("post_rst_blank", 32'(rgb), 32'h000);
    run_to(152, 60);
    chk("pix_152_60", 32'(rgb), 32'(EDGE_BG));
    run_to(153, 61);
    chk("pix_153_61", 32'(rgb), 32'h000);
    run_to(0, 62);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
